// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - fetch-to-decode boundary register with one-entry skid and post-flush drop
//
// clk        rising-edge clock
// rst        synchronous active-high reset
// in_valid   upstream word valid
// in_pc      PC paired with in_inst
// in_inst    instruction word from BRAM
// in_ready   registered; stage can take a word this cycle
// flush      discard held and in-flight words
// out_valid  out_pc/out_inst valid for decode
// out_pc     PC presented to decode
// out_inst   instruction presented to decode (NOP_INST when invalid)
// out_ready  decode consumes the word this cycle

module if_id_skid #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013,
  parameter int                    FLUSH_DROP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t                state_q, state_nxt;
  logic                  in_ready_q;
  logic [1:0]            drop_cnt;
  logic [PC_WIDTH-1:0]   main_pc, skid_pc;
  logic [INST_WIDTH-1:0] main_inst, skid_inst;

  logic accept;
  logic drop_beat;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // A beat is taken off the bus whenever valid meets ready; while drop_cnt
  // is nonzero it is thrown away instead of being stored.
  assign accept    = in_valid & in_ready_q & (drop_cnt == 2'd0);
  assign drop_beat = in_valid & in_ready_q & (drop_cnt != 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every handshake
  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_nxt = S_ONE;
        S_ONE: begin
          if (accept && !out_ready)      state_nxt = S_TWO;
          else if (!accept && out_ready) state_nxt = S_EMPTY;
        end
        S_TWO:   if (out_ready) state_nxt = S_ONE;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Output / datapath-control logic
  always_comb begin
    out_valid      = (state_q != S_EMPTY);
    out_pc         = main_pc;
    out_inst       = out_valid ? main_inst : NOP_INST;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (state_q)
        S_EMPTY: load_main_in   = accept;
        S_ONE: begin
          load_main_in = accept & out_ready;
          load_skid    = accept & ~out_ready;
        end
        S_TWO:   load_main_skid = out_ready;
        default: ;
      endcase
    end
  end

  // in_ready is derived from the next state so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_nxt != S_TWO);
    end
  end

  assign in_ready = in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_pc   <= '0;
      main_inst <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      drop_cnt  <= 2'd0;
    end else begin
      // A flush (even during an active drop window) restarts the count.
      if (flush) begin
        drop_cnt <= 2'(FLUSH_DROP);
      end else if (drop_beat) begin
        drop_cnt <= drop_cnt - 2'd1;
      end

      if (load_main_in) begin
        main_pc   <= in_pc;
        main_inst <= in_inst;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end

      if (load_skid) begin
        skid_pc   <= in_pc;
        skid_inst <= in_inst;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - directed and constrained-random check of if_id_skid
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1;
  logic [31:0] out_pc1, out_inst1;
  logic        in_ready0, out_valid0;
  logic [31:0] out_pc0, out_inst0;
  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2, out_inst2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_skid #(.PC_WIDTH(32), .INST_WIDTH(32), .NOP_INST(NOP), .FLUSH_DROP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready1), .flush(flush), .out_valid(out_valid1), .out_pc(out_pc1),
    .out_inst(out_inst1), .out_ready(out_ready));

  if_id_skid #(.PC_WIDTH(32), .INST_WIDTH(32), .NOP_INST(NOP), .FLUSH_DROP(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready0), .flush(flush), .out_valid(out_valid0), .out_pc(out_pc0),
    .out_inst(out_inst0), .out_ready(out_ready));

  if_id_skid #(.PC_WIDTH(32), .INST_WIDTH(32), .NOP_INST(NOP), .FLUSH_DROP(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready2), .flush(flush), .out_valid(out_valid2), .out_pc(out_pc2),
    .out_inst(out_inst2), .out_ready(out_ready));

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = mk_inst(pc);
    out_ready = ordy;
    flush     = fl;
  endtask

  logic [31:0] q[$];
  int          drop_m;
  logic [31:0] up_pc;
  logic        pre_rdy, pre_v;
  logic [31:0] pre_pc, pre_inst;

  initial begin
    // Reset then stream
    drive(0, 32'h0, 0, 0);
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_pc", out_pc1, 0);
    chk("rst_out_inst", out_inst1, NOP);
    chk("rst_in_ready", in_ready1, 1);
    drive(1, 32'h00, 1, 0); cyc();
    chk("s_valid0", out_valid1, 1);
    chk("s_pc0", out_pc1, 32'h00);
    drive(1, 32'h04, 1, 0); cyc();
    chk("s_pc4", out_pc1, 32'h04);
    chk("s_rdy4", in_ready1, 1);
    drive(1, 32'h08, 1, 0); cyc();
    chk("s_pc8", out_pc1, 32'h08);
    chk("s_inst8", out_inst1, mk_inst(32'h08));
    chk("s_rdy8", in_ready1, 1);
    drive(0, 32'h0, 1, 0); cyc();
    chk("s_drain_valid", out_valid1, 0);
    chk("s_drain_inst", out_inst1, NOP);

    // Stall into skid
    drive(1, 32'h10, 1, 0); cyc();
    chk("k_pc10", out_pc1, 32'h10);
    drive(1, 32'h14, 0, 0); cyc();
    chk("k_hold_pc", out_pc1, 32'h10);
    chk("k_rdy0", in_ready1, 0);
    drive(1, 32'h18, 0, 0); cyc();
    chk("k_hold_pc2", out_pc1, 32'h10);
    chk("k_hold_inst2", out_inst1, mk_inst(32'h10));
    chk("k_rdy0b", in_ready1, 0);
    drive(1, 32'h18, 1, 0); cyc();
    chk("k_pc14", out_pc1, 32'h14);
    chk("k_rdy1", in_ready1, 1);
    drive(1, 32'h18, 1, 0); cyc();
    chk("k_pc18", out_pc1, 32'h18);
    chk("k_valid18", out_valid1, 1);
    drive(0, 32'h0, 1, 0); cyc();
    chk("k_empty", out_valid1, 0);

    // Flush from TWO, FLUSH_DROP=1 on u1 and 0 on u0
    drive(1, 32'h20, 0, 0); cyc();
    drive(1, 32'h24, 0, 0); cyc();
    chk("f_two_rdy", in_ready1, 0);
    drive(0, 32'h0, 1, 1); cyc();
    chk("f_valid", out_valid1, 0);
    chk("f_inst", out_inst1, NOP);
    chk("f_rdy", in_ready1, 1);
    drive(1, 32'h28, 1, 0); cyc();
    chk("f_drop28", out_valid1, 0);
    chk("f0_take28", out_pc0, 32'h28);
    chk("f0_valid28", out_valid0, 1);
    drive(1, 32'h40, 1, 0); cyc();
    chk("f_valid40", out_valid1, 1);
    chk("f_pc40", out_pc1, 32'h40);
    chk("f0_pc40", out_pc0, 32'h40);
    drive(0, 32'h0, 1, 0); cyc();

    // Flush during drop window on u2 (FLUSH_DROP=2)
    rst = 1'b1; cyc(); rst = 1'b0;
    drive(0, 32'h0, 1, 1); cyc();
    drive(1, 32'h60, 1, 0); cyc();
    chk("d_drop60", out_valid2, 0);
    drive(1, 32'h5C, 1, 1); cyc();
    chk("d_flush_cyc", out_valid2, 0);
    drive(1, 32'h64, 1, 0); cyc();
    chk("d_drop64", out_valid2, 0);
    drive(1, 32'h68, 1, 0); cyc();
    chk("d_drop68", out_valid2, 0);
    drive(1, 32'h6C, 1, 0); cyc();
    chk("d_valid6c", out_valid2, 1);
    chk("d_pc6c", out_pc2, 32'h6C);
    drive(0, 32'h0, 1, 0); cyc();

    // Reset mid-operation with flush in TWO
    drive(1, 32'h30, 0, 0); cyc();
    drive(1, 32'h34, 0, 0); cyc();
    chk("r_two_rdy", in_ready1, 0);
    drive(1, 32'h38, 1, 1); rst = 1'b1; cyc(); rst = 1'b0;
    chk("r_valid", out_valid1, 0);
    chk("r_pc", out_pc1, 0);
    chk("r_inst", out_inst1, NOP);
    chk("r_rdy", in_ready1, 1);
    drive(1, 32'h50, 1, 0); cyc();
    chk("r_pc50", out_pc1, 32'h50);
    chk("r_valid50", out_valid1, 1);
    chk("r2_pc50", out_pc2, 32'h50);
    drive(0, 32'h0, 1, 0); cyc();

    // Random traffic on u1 against a reference queue
    rst = 1'b1; cyc(); rst = 1'b0;
    q.delete();
    drop_m = 0;
    up_pc  = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, up_pc, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      pre_rdy  = in_ready1;
      pre_v    = out_valid1;
      pre_pc   = out_pc1;
      pre_inst = out_inst1;
      chk("rnd_in_ready", pre_rdy, q.size() != 2);
      chk("rnd_out_valid", pre_v, q.size() != 0);
      if (flush) begin
        q.delete();
        drop_m = 1;
      end else begin
        if (pre_v && out_ready && q.size() > 0) begin
          chk("rnd_out_pc", pre_pc, q[0]);
          chk("rnd_out_inst", pre_inst, mk_inst(q[0]));
          void'(q.pop_front());
        end
        if (in_valid && pre_rdy) begin
          if (drop_m > 0) drop_m--;
          else q.push_back(up_pc);
        end
      end
      if (in_valid && pre_rdy) up_pc = up_pc + 32'd4;
      cyc();
      if (pre_v && !out_ready && !flush) begin
        chk("rnd_stable_valid", out_valid1, 1);
        chk("rnd_stable_pc", out_pc1, pre_pc);
        chk("rnd_stable_inst", out_inst1, pre_inst);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
